// File: rtl/minisrc_control_sequencer.sv
// Hardwired T0..T6 control sequencer for the Mini SRC bus datapath.
// Strobes are decoded combinationally from the state register, IR and MemDone.
module minisrc_control_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Run,
    input  logic [31:0]      IR,
    input  logic             MemDone,
    output logic             PCout,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             MDRout,
    output logic [15:0]      Rout,
    output logic [15:0]      Rin,
    output logic             MARin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             LOin,
    output logic             HIin,
    output logic             IncPC,
    output logic             Read,
    output logic             RAMRead,
    output logic [12:0]      AluOp,
    output logic             Busy,
    output logic             Halted,
    output logic             Fault,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED, S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [4:0]  opcode;
    logic [3:0]  ra, rb, rc;
    logic [14:0] ir_unused;
    logic        is_alu3, is_muldiv, is_unary, is_nop, is_halt;
    logic [12:0] alu_sel;
    logic        retire;

    assign opcode    = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign ir_unused = IR[14:0];

    function automatic logic [15:0] reg_sel(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    // R0 is hardwired to zero, so its load enable is never raised.
    function automatic logic [15:0] reg_load(input logic [3:0] idx);
        return reg_sel(idx) & 16'hFFFE;
    endfunction

    always_comb begin
        is_alu3   = 1'b0;
        is_muldiv = 1'b0;
        is_unary  = 1'b0;
        is_nop    = 1'b0;
        is_halt   = 1'b0;
        alu_sel   = 13'h0000;
        case (opcode)
            5'b00011: begin is_alu3 = 1'b1;   alu_sel = 13'h0800; end
            5'b00100: begin is_alu3 = 1'b1;   alu_sel = 13'h0400; end
            5'b00101: begin is_alu3 = 1'b1;   alu_sel = 13'h1000; end
            5'b00110: begin is_alu3 = 1'b1;   alu_sel = 13'h0004; end
            5'b00111: begin is_alu3 = 1'b1;   alu_sel = 13'h0010; end
            5'b01000: begin is_alu3 = 1'b1;   alu_sel = 13'h0008; end
            5'b01001: begin is_alu3 = 1'b1;   alu_sel = 13'h0080; end
            5'b01010: begin is_alu3 = 1'b1;   alu_sel = 13'h0040; end
            5'b01011: begin is_alu3 = 1'b1;   alu_sel = 13'h0020; end
            5'b01111: begin is_muldiv = 1'b1; alu_sel = 13'h0200; end
            5'b10000: begin is_muldiv = 1'b1; alu_sel = 13'h0100; end
            5'b10001: begin is_unary = 1'b1;  alu_sel = 13'h0002; end
            5'b10010: begin is_unary = 1'b1;  alu_sel = 13'h0001; end
            5'b11010: is_nop  = 1'b1;
            5'b11011: is_halt = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        retire   = 1'b0;
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        MDRout   = 1'b0;
        Rout     = 16'h0000;
        Rin      = 16'h0000;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        LOin     = 1'b0;
        HIin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        RAMRead  = 1'b0;
        AluOp    = 13'h0000;
        case (state_q)
            S_IDLE: if (Run) state_d = S_T0;
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = S_T1;
            end
            // Hold the memory read until RAM reports completion; PC loads on that cycle.
            S_T1: begin
                Zlowout = 1'b1;
                Read    = 1'b1;
                RAMRead = 1'b1;
                MDRin   = 1'b1;
                if (MemDone) begin
                    PCin    = 1'b1;
                    state_d = S_T2;
                end
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                if (is_alu3) begin
                    Rout    = reg_sel(rb);
                    Yin     = 1'b1;
                    state_d = S_T4;
                end else if (is_muldiv) begin
                    Rout    = reg_sel(ra);
                    Yin     = 1'b1;
                    state_d = S_T4;
                end else if (is_unary) begin
                    Rout    = reg_sel(rb);
                    AluOp   = alu_sel;
                    Zin     = 1'b1;
                    state_d = S_T4;
                end else if (is_nop) begin
                    retire  = 1'b1;
                end else if (is_halt) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_T4: begin
                if (is_alu3) begin
                    Rout  = reg_sel(rc);
                    AluOp = alu_sel;
                    Zin   = 1'b1;
                end else if (is_muldiv) begin
                    Rout  = reg_sel(rb);
                    AluOp = alu_sel;
                    Zin   = 1'b1;
                end
                state_d = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_muldiv) begin
                    LOin    = 1'b1;
                    state_d = S_T6;
                end else begin
                    Rin    = reg_load(ra);
                    retire = 1'b1;
                end
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                retire   = 1'b1;
            end
            default: ;
        endcase
        // Run is only consulted here and in IDLE, so a dropped Run lets the instruction finish.
        if (retire) begin
            count_d = count_q + CNT_W'(1);
            state_d = Run ? S_T0 : S_IDLE;
        end
    end

    assign Busy       = (state_q != S_IDLE) && (state_q != S_HALTED) && (state_q != S_FAULT);
    assign Halted     = (state_q == S_HALTED);
    assign Fault      = (state_q == S_FAULT);
    assign InstrCount = count_q;

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_minisrc_control_sequencer.sv
// Directed bench: per-cycle expected strobe vectors built from instruction class rules.
module tb_minisrc_control_sequencer;

    typedef struct packed {
        logic        pcout, zlowout, zhighout, mdrout;
        logic [15:0] rout, rin;
        logic        marin, pcin, mdrin, irin, yin, zin, loin, hiin, incpc, read, ramread;
        logic [12:0] aluop;
        logic        busy, halted, fault;
        logic [15:0] cnt;
    } vec_t;

    localparam int VW = $bits(vec_t);

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        Run = 1'b0;
    logic        MemDone = 1'b1;
    logic [31:0] IR = 32'h0;

    logic        PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin;
    logic        LOin, HIin, IncPC, Read, RAMRead, Busy, Halted, Fault;
    logic [15:0] Rout, Rin, InstrCount;
    logic [12:0] AluOp;

    logic        s_PCout, s_Zlowout, s_Zhighout, s_MDRout, s_MARin, s_PCin, s_MDRin, s_IRin;
    logic        s_Yin, s_Zin, s_LOin, s_HIin, s_IncPC, s_Read, s_RAMRead, s_Busy, s_Halted, s_Fault;
    logic [15:0] s_Rout, s_Rin;
    logic [12:0] s_AluOp;
    logic [3:0]  s_InstrCount;

    minisrc_control_sequencer #(.CNT_W(16)) dut (
        .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR), .MemDone(MemDone),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .Rout(Rout), .Rin(Rin), .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .LOin(LOin), .HIin(HIin), .IncPC(IncPC), .Read(Read),
        .RAMRead(RAMRead), .AluOp(AluOp), .Busy(Busy), .Halted(Halted), .Fault(Fault),
        .InstrCount(InstrCount)
    );

    // Narrow-counter copy so counter wrap is reachable in a short run.
    minisrc_control_sequencer #(.CNT_W(4)) dut_small (
        .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR), .MemDone(MemDone),
        .PCout(s_PCout), .Zlowout(s_Zlowout), .Zhighout(s_Zhighout), .MDRout(s_MDRout),
        .Rout(s_Rout), .Rin(s_Rin), .MARin(s_MARin), .PCin(s_PCin), .MDRin(s_MDRin),
        .IRin(s_IRin), .Yin(s_Yin), .Zin(s_Zin), .LOin(s_LOin), .HIin(s_HIin),
        .IncPC(s_IncPC), .Read(s_Read), .RAMRead(s_RAMRead), .AluOp(s_AluOp),
        .Busy(s_Busy), .Halted(s_Halted), .Fault(s_Fault), .InstrCount(s_InstrCount)
    );

    vec_t dv, sv;
    assign dv = {PCout, Zlowout, Zhighout, MDRout, Rout, Rin, MARin, PCin, MDRin, IRin, Yin, Zin,
                 LOin, HIin, IncPC, Read, RAMRead, AluOp, Busy, Halted, Fault, InstrCount};
    assign sv = {s_PCout, s_Zlowout, s_Zhighout, s_MDRout, s_Rout, s_Rin, s_MARin, s_PCin, s_MDRin,
                 s_IRin, s_Yin, s_Zin, s_LOin, s_HIin, s_IncPC, s_Read, s_RAMRead, s_AluOp,
                 s_Busy, s_Halted, s_Fault, {12'h000, s_InstrCount}};

    always #5 Clock = ~Clock;

    int          checks = 0;
    int          errors = 0;
    int          ncyc = 0;
    logic [15:0] mcount = 16'h0;
    vec_t        exp_q[$];
    vec_t        ev[4];
    int          en;
    int          ekind;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] alu_of(input logic [4:0] op);
        case (op)
            5'b00101: return 13'h1000;
            5'b00011: return 13'h0800;
            5'b00100: return 13'h0400;
            5'b01111: return 13'h0200;
            5'b10000: return 13'h0100;
            5'b01001: return 13'h0080;
            5'b01010: return 13'h0040;
            5'b01011: return 13'h0020;
            5'b00111: return 13'h0010;
            5'b01000: return 13'h0008;
            5'b00110: return 13'h0004;
            5'b10001: return 13'h0002;
            5'b10010: return 13'h0001;
            default:  return 13'h0000;
        endcase
    endfunction

    // Execute-phase steps (T3 onward) for one instruction, by class.
    function automatic void model_exec(input logic [31:0] ir);
        int          op;
        logic [15:0] one;
        vec_t        b;
        op  = int'(ir[31:27]);
        one = 16'h0001;
        b = '0;
        b.busy = 1'b1;
        for (int i = 0; i < 4; i++) ev[i] = b;
        ekind = 0;
        en = 1;
        if (op >= 3 && op <= 11) begin
            ev[0].rout = one << ir[22:19]; ev[0].yin = 1'b1;
            ev[1].rout = one << ir[18:15]; ev[1].aluop = alu_of(ir[31:27]); ev[1].zin = 1'b1;
            ev[2].zlowout = 1'b1; ev[2].rin = (one << ir[26:23]) & 16'hFFFE;
            en = 3;
        end else if (op == 15 || op == 16) begin
            ev[0].rout = one << ir[26:23]; ev[0].yin = 1'b1;
            ev[1].rout = one << ir[22:19]; ev[1].aluop = alu_of(ir[31:27]); ev[1].zin = 1'b1;
            ev[2].zlowout = 1'b1; ev[2].loin = 1'b1;
            ev[3].zhighout = 1'b1; ev[3].hiin = 1'b1;
            en = 4;
        end else if (op == 17 || op == 18) begin
            ev[0].rout = one << ir[22:19]; ev[0].aluop = alu_of(ir[31:27]); ev[0].zin = 1'b1;
            ev[2].zlowout = 1'b1; ev[2].rin = (one << ir[26:23]) & 16'hFFFE;
            en = 3;
        end else if (op == 26) begin
            en = 1;
        end else if (op == 27) begin
            ekind = 1;
        end else begin
            ekind = 2;
        end
    endfunction

    always @(negedge Clock) begin
        vec_t e, es;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            es = e;
            es.cnt = {12'h000, e.cnt[3:0]};
            chk("outputs", dv, e);
            chk("outputs_small", sv, es);
        end
    end

    task automatic cyc(input vec_t v, input logic run, input logic md);
        Run = run;
        MemDone = md;
        v.cnt = mcount;
        exp_q.push_back(v);
        ncyc++;
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input logic run);
        vec_t z;
        z = '0;
        cyc(z, run, 1'b1);
    endtask

    task automatic run_instr(input logic [31:0] ir, input int waits, input logic run_after,
                             input int stop, output int cycles);
        vec_t t;
        int   start;
        start = ncyc;
        IR = ir;
        model_exec(ir);
        t = '0; t.busy = 1'b1; t.pcout = 1'b1; t.marin = 1'b1; t.incpc = 1'b1; t.zin = 1'b1;
        cyc(t, 1'b1, 1'b1);
        t = '0; t.busy = 1'b1; t.zlowout = 1'b1; t.read = 1'b1; t.ramread = 1'b1; t.mdrin = 1'b1;
        for (int i = 0; i < waits; i++) cyc(t, 1'b1, 1'b0);
        t.pcin = 1'b1;
        cyc(t, 1'b1, 1'b1);
        t = '0; t.busy = 1'b1; t.mdrout = 1'b1; t.irin = 1'b1;
        cyc(t, 1'b1, 1'b1);
        for (int i = 0; i < en && i < stop; i++) cyc(ev[i], run_after, 1'b1);
        if (ekind == 0 && stop >= en) mcount = mcount + 16'h1;
        cycles = ncyc - start;
    endtask

    task automatic clear_pulse();
        Clear = 1'b1;
        Run = 1'b0;
        #1;
        chk("clear_async_zero", dv, VW'(0));
        mcount = 16'h0;
        @(posedge Clock);
        #1;
        Clear = 1'b0;
    endtask

    initial begin
        int   c;
        vec_t hv;
        #2;
        chk("reset_outputs", dv, VW'(0));
        @(posedge Clock);
        #1;
        Clear = 1'b0;
        idle(1'b0);
        idle(1'b0);

        idle(1'b1);
        run_instr(32'h1A920000, 0, 1'b1, 99, c);
        chk("add_t3_rout", VW'(ev[0].rout), VW'(16'h0004));
        chk("add_t4_rout", VW'(ev[1].rout), VW'(16'h0010));
        chk("add_t4_aluop", VW'(ev[1].aluop), VW'(13'h0800));
        chk("add_t5_rin", VW'(ev[2].rin), VW'(16'h0020));
        chk("add_cycles", VW'(c), VW'(6));
        chk("add_count", VW'(InstrCount), VW'(16'd1));

        run_instr(32'h1A920000, 3, 1'b1, 99, c);
        chk("memwait_cycles", VW'(c), VW'(9));

        run_instr(32'h79880000, 0, 1'b1, 99, c);
        chk("mul_steps", VW'(en), VW'(4));
        chk("mul_t5_loin", VW'(ev[2].loin), VW'(1));
        chk("mul_cycles", VW'(c), VW'(7));

        run_instr(32'h90380000, 0, 1'b1, 99, c);
        chk("not_r0_rin", VW'(ev[2].rin), VW'(16'h0000));
        chk("not_cycles", VW'(c), VW'(6));
        chk("not_count", VW'(InstrCount), VW'(16'd4));

        run_instr(32'hD0000000, 0, 1'b0, 99, c);
        chk("nop_cycles", VW'(c), VW'(4));
        idle(1'b0);

        idle(1'b1);
        run_instr(32'h1A920000, 0, 1'b0, 99, c);
        idle(1'b0);
        idle(1'b0);
        chk("run_drop_count", VW'(InstrCount), VW'(16'd6));

        idle(1'b1);
        for (int i = 0; i < 10; i++) run_instr(32'hD0000000, 0, (i != 9), 99, c);
        idle(1'b0);
        chk("count_16", VW'(InstrCount), VW'(16'd16));
        chk("small_count_wrap", VW'(s_InstrCount), VW'(4'h0));

        idle(1'b1);
        run_instr(32'h1A920000, 0, 1'b1, 1, c);
        chk("mid_t4_zin", VW'(Zin), VW'(1));
        clear_pulse();
        for (int i = 0; i < 3; i++) idle(1'b0);

        idle(1'b1);
        run_instr(32'hD0000000, 0, 1'b1, 99, c);
        run_instr(32'hD8000000, 0, 1'b1, 99, c);
        chk("halt_cycles", VW'(c), VW'(4));
        hv = '0; hv.halted = 1'b1;
        for (int i = 0; i < 3; i++) cyc(hv, 1'b1, 1'b1);
        chk("halted_flag", VW'({Halted, Busy}), VW'(2'b10));
        chk("halt_count", VW'(InstrCount), VW'(16'd1));
        clear_pulse();
        idle(1'b0);

        idle(1'b1);
        run_instr(32'hF8000000, 0, 1'b1, 99, c);
        hv = '0; hv.fault = 1'b1;
        for (int i = 0; i < 3; i++) cyc(hv, 1'b1, 1'b1);
        chk("fault_flag", VW'({Fault, Busy}), VW'(2'b10));
        chk("fault_count", VW'(InstrCount), VW'(16'd0));
        clear_pulse();
        idle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
